// File: rtl/nsa_pkg.sv
// Shared types and constants for the nibble-serial add/subtract engine.
package nsa_pkg;

    // Operation sequencing: wait for operands, walk the nibbles, hold the result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the combinational adder slice.
    localparam int NIBBLE_W = 4;

    // Index counter width; kept at least one bit so a single-nibble engine still has a counter.
    function automatic int idx_width(input int nib);
        return (nib > 1) ? $clog2(nib) : 1;
    endfunction

endpackage

// File: rtl/nibble_add4.sv
// 4-bit combinational adder slice. Also exposes the carry into bit 3 so the
// caller can form the two's-complement overflow flag on the top nibble.
module nibble_add4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co,
    output logic       c3
);

    logic [3:0] w_lo;
    logic [1:0] w_hi;

    // Split at bit 3 so the internal carry into the sign position is visible.
    always_comb begin
        w_lo = {1'b0, a[2:0]} + {1'b0, b[2:0]} + {3'b000, ci};
        c3   = w_lo[3];
        w_hi = {1'b0, a[3]} + {1'b0, b[3]} + {1'b0, w_lo[3]};
        s    = {w_hi[0], w_lo[2:0]};
        co   = w_hi[1];
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle add/subtract engine: one operand pair per handshake, processed
// one nibble per clock (LS nibble first) through a single 4-bit slice.
module nibble_serial_adder
    import nsa_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_zero,
    output logic             out_ovf
);

    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int IDX_W = idx_width(NIB);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [IDX_W-1:0]   r_idx;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_carry;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_zero;
    logic               r_ovf;

    logic [3:0]         w_s;
    logic               w_co;
    logic               w_c3;
    logic               w_last;
    logic [WIDTH-1:0]   w_acc_shift;

    // Operands are shifted right each RUN cycle, so the active nibble is always at the bottom.
    nibble_add4 u_slice (
        .a  (r_a[NIBBLE_W-1:0]),
        .b  (r_b[NIBBLE_W-1:0]),
        .ci (r_carry),
        .s  (w_s),
        .co (w_co),
        .c3 (w_c3)
    );

    // New sum nibble enters at the top; after NIB shifts nibble 0 sits at the bottom.
    always_comb begin
        w_acc_shift = (WIDTH'(w_s) << (WIDTH - NIBBLE_W)) | (r_acc >> NIBBLE_W);
        w_last      = (r_state == RUN) && (r_idx == LAST_IDX);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Datapath: latch operands on accept, walk nibbles in RUN, capture result on the last nibble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_acc   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_zero  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        // Subtract as A + ~B + ~borrow_in.
                        r_a     <= in_a;
                        r_b     <= in_b ^ {WIDTH{in_sub}};
                        r_carry <= in_cin ^ in_sub;
                        r_acc   <= '0;
                        r_idx   <= '0;
                    end
                end
                RUN: begin
                    r_a     <= r_a >> NIBBLE_W;
                    r_b     <= r_b >> NIBBLE_W;
                    r_acc   <= w_acc_shift;
                    r_carry <= w_co;
                    if (w_last) begin
                        r_sum  <= w_acc_shift;
                        r_cout <= w_co;
                        r_ovf  <= w_c3 ^ w_co;
                        r_zero <= (w_acc_shift == '0);
                    end else begin
                        r_idx  <= r_idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign out_sum  = r_sum;
    assign out_cout = r_cout;
    assign out_zero = r_zero;
    assign out_ovf  = r_ovf;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder: a 16-bit instance and a 4-bit instance.
module tb_nibble_serial_adder;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        zero;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // 16-bit instance signals
    logic        iv16, ir16, sub16, cin16, ov16, ordy16, cout16, zero16, ovf16;
    logic [15:0] a16, b16, sum16;
    // 4-bit instance signals
    logic        iv4, ir4, sub4, cin4, ov4, ordy4, cout4, zero4, ovf4;
    logic [3:0]  a4, b4, sum4;

    int   checks = 0;
    int   errors = 0;
    exp_t q16[$];
    exp_t q4[$];
    exp_t m16_e;
    exp_t m4_e;

    nibble_serial_adder #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv16), .in_ready(ir16), .in_a(a16), .in_b(b16),
        .in_sub(sub16), .in_cin(cin16),
        .out_valid(ov16), .out_ready(ordy16), .out_sum(sum16),
        .out_cout(cout16), .out_zero(zero16), .out_ovf(ovf16)
    );

    nibble_serial_adder #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv4), .in_ready(ir4), .in_a(a4), .in_b(b4),
        .in_sub(sub4), .in_cin(cin4),
        .out_valid(ov4), .out_ready(ordy4), .out_sum(sum4),
        .out_cout(cout4), .out_zero(zero4), .out_ovf(ovf4)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Monitor for the 16-bit instance: compares on every output handshake.
    always @(negedge clk) begin
        if (rst_n && ov16 && ordy16) begin
            if (q16.size() == 0) begin
                chk("unexpected_out16", 64'(ov16), 64'd0);
            end else begin
                m16_e = q16.pop_front();
                $display("txn16 sum=%h cout=%b zero=%b ovf=%b (exp %h %b %b %b)",
                         sum16, cout16, zero16, ovf16, m16_e.sum, m16_e.cout, m16_e.zero, m16_e.ovf);
                chk("sum16",  64'(sum16),  64'(m16_e.sum));
                chk("cout16", 64'(cout16), 64'(m16_e.cout));
                chk("zero16", 64'(zero16), 64'(m16_e.zero));
                chk("ovf16",  64'(ovf16),  64'(m16_e.ovf));
            end
        end
    end

    // Monitor for the 4-bit instance.
    always @(negedge clk) begin
        if (rst_n && ov4 && ordy4) begin
            if (q4.size() == 0) begin
                chk("unexpected_out4", 64'(ov4), 64'd0);
            end else begin
                m4_e = q4.pop_front();
                $display("txn4 sum=%h cout=%b zero=%b ovf=%b (exp %h %b %b %b)",
                         sum4, cout4, zero4, ovf4, m4_e.sum[3:0], m4_e.cout, m4_e.zero, m4_e.ovf);
                chk("sum4",  64'(sum4),  64'(m4_e.sum[3:0]));
                chk("cout4", 64'(cout4), 64'(m4_e.cout));
                chk("zero4", 64'(zero4), 64'(m4_e.zero));
                chk("ovf4",  64'(ovf4),  64'(m4_e.ovf));
            end
        end
    end

    // One 16-bit operation; called at #1 after a posedge with the engine idle.
    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic sub, input logic cin,
                        input logic [15:0] esum, input logic ecout, input logic ezero, input logic eovf,
                        input int hold, input bit chk_lat);
        int n;
        chk("in_ready16_idle", 64'(ir16), 64'd1);
        q16.push_back('{sum: esum, cout: ecout, zero: ezero, ovf: eovf});
        ordy16 = (hold == 0);
        a16 = a; b16 = b; sub16 = sub; cin16 = cin; iv16 = 1'b1;
        @(posedge clk); #1;
        iv16 = 1'b0;
        // Scramble operands while running: result must not change.
        a16 = 16'($urandom); b16 = 16'($urandom); sub16 = 1'($urandom); cin16 = 1'($urandom);
        n = 1;
        while (!ov16 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("out_valid16_seen", 64'(ov16), 64'd1);
        if (chk_lat) chk("latency16", 64'(n), 64'd5);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid16", 64'(ov16), 64'd1);
            chk("hold_ready16", 64'(ir16), 64'd0);
            chk("hold_sum16",   64'(sum16), 64'(esum));
        end
        ordy16 = 1'b1;
        @(posedge clk); #1;
    endtask

    // One 4-bit operation.
    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic sub, input logic cin,
                       input logic [3:0] esum, input logic ecout, input logic ezero, input logic eovf);
        int n;
        q4.push_back('{sum: 16'(esum), cout: ecout, zero: ezero, ovf: eovf});
        a4 = a; b4 = b; sub4 = sub; cin4 = cin; iv4 = 1'b1;
        @(posedge clk); #1;
        iv4 = 1'b0;
        a4 = 4'($urandom); b4 = 4'($urandom);
        n = 1;
        while (!ov4 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("out_valid4_seen", 64'(ov4), 64'd1);
        chk("latency4", 64'(n), 64'd2);
        @(posedge clk); #1;
    endtask

    initial begin
        int rises[3];
        int k;
        int cyc;
        logic prev;
        iv16 = 0; a16 = 0; b16 = 0; sub16 = 0; cin16 = 0; ordy16 = 1;
        iv4 = 0;  a4 = 0;  b4 = 0;  sub4 = 0;  cin4 = 0;  ordy4 = 1;

        // Reset state
        #1;
        chk("rst_in_ready",  64'(ir16),  64'd1);
        chk("rst_out_valid", 64'(ov16),  64'd0);
        chk("rst_sum",       64'(sum16), 64'd0);
        chk("rst_flags",     64'({cout16, zero16, ovf16}), 64'd0);
        #11 rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors
        op16(16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        op16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 0, 1'b0);
        op16(16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b0, 1'b1, 0, 1'b0);
        op16(16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        op16(16'h7FFF, 16'h0000, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        op16(16'hA5A5, 16'h5A5A, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 0, 1'b0);
        op16(16'h1234, 16'h1234, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 0, 1'b0);
        // Backpressure: result held for 10 cycles
        op16(16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1, 10, 1'b0);

        // Reset on the second RUN cycle: operation discarded
        a16 = 16'h1111; b16 = 16'h2222; sub16 = 1'b0; cin16 = 1'b0; iv16 = 1'b1;
        @(posedge clk); #1;
        iv16 = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(ov16),  64'd0);
        chk("midrst_in_ready",  64'(ir16),  64'd1);
        chk("midrst_sum",       64'(sum16), 64'd0);
        chk("midrst_flags",     64'({cout16, zero16, ovf16}), 64'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("postrst_no_valid", 64'(ov16), 64'd0);
        end
        op16(16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, 0, 1'b1);

        // Back-to-back with in_valid held: one result every 6 clocks
        for (int i = 0; i < 3; i++)
            q16.push_back('{sum: 16'h0303, cout: 1'b0, zero: 1'b0, ovf: 1'b0});
        a16 = 16'h0101; b16 = 16'h0202; sub16 = 1'b0; cin16 = 1'b0; ordy16 = 1'b1; iv16 = 1'b1;
        k = 0; cyc = 0; prev = 1'b0;
        while (k < 3 && cyc < 80) begin
            @(posedge clk); #1;
            cyc++;
            if (ov16 && !prev) begin
                rises[k] = cyc;
                k++;
            end
            prev = ov16;
            if (k == 3) iv16 = 1'b0;
        end
        iv16 = 1'b0;
        chk("b2b_count", 64'(k), 64'd3);
        if (k == 3) begin
            chk("b2b_gap1", 64'(rises[1] - rises[0]), 64'd6);
            chk("b2b_gap2", 64'(rises[2] - rises[1]), 64'd6);
        end
        repeat (4) @(posedge clk);
        #1;

        // WIDTH=4 instance
        op4(4'hF, 4'h1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
        op4(4'h7, 4'h1, 1'b0, 1'b0, 4'h8, 1'b0, 1'b0, 1'b1);
        op4(4'h0, 4'h1, 1'b1, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0);

        repeat (5) @(posedge clk);
        #1;
        chk("q16_drained", 64'(q16.size()), 64'd0);
        chk("q4_drained",  64'(q4.size()),  64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global bound on run time.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
